// File: rtl/ac97_link_receiver.sv
// AC-link receive deserializer: frames codec SDATA_IN on ac97_sync rises and publishes the slot 0 tag,
// the status read-back and the PCM capture. Define AC97_RX_FRAME_STATS_EN to add frame/error counters.
module ac97_link_receiver #(
  parameter int BIT0_DELAY = 1,
  parameter int PCM_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 ac97_sync,
  input  logic                 ac97_sdata_in,
  output logic                 codec_ready,
  output logic [11:0]          slot_tags,
  output logic [6:0]           status_addr,
  output logic [15:0]          status_data,
  output logic                 status_valid,
  output logic [PCM_WIDTH-1:0] pcm_left,
  output logic [PCM_WIDTH-1:0] pcm_right,
  output logic                 pcm_valid,
`ifdef AC97_RX_FRAME_STATS_EN
  output logic [15:0]          frame_count,
  output logic [7:0]           error_count,
`endif
  output logic                 frame_error
);

  typedef enum logic [1:0] {HUNT, ALIGN, SLOT0, DATA} state_t;

  state_t                 r_state;
  logic                   r_sync_d;
  logic [7:0]             r_bit_cnt;
  logic [18:0]            r_shift;
  logic [6:0]             r_addr_hold;
  logic [PCM_WIDTH-1:0]   r_left_hold;

  logic                   w_sync_rise;
  logic                   w_sample;
  logic [19:0]            w_slot;
  logic                   w_unused;

  // w_slot is the 20 most recent bits including the one being sampled this edge.
  assign w_slot   = {r_shift, ac97_sdata_in};
  assign w_unused = ^w_slot[2:0];

  always_comb begin
    w_sync_rise = ac97_sync & ~r_sync_d;
    w_sample    = 1'b0;
    if (w_sync_rise)
      w_sample = (BIT0_DELAY == 0);
    else if (r_state == ALIGN)
      w_sample = (r_bit_cnt == 8'(BIT0_DELAY));
    else if (r_state == SLOT0 || r_state == DATA)
      w_sample = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state      <= HUNT;
      r_sync_d     <= 1'b0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_addr_hold  <= '0;
      r_left_hold  <= '0;
      codec_ready  <= 1'b0;
      slot_tags    <= '0;
      status_addr  <= '0;
      status_data  <= '0;
      status_valid <= 1'b0;
      pcm_left     <= '0;
      pcm_right    <= '0;
      pcm_valid    <= 1'b0;
      frame_error  <= 1'b0;
`ifdef AC97_RX_FRAME_STATS_EN
      frame_count  <= '0;
      error_count  <= '0;
`endif
    end else begin
      r_sync_d     <= ac97_sync;
      status_valid <= 1'b0;
      pcm_valid    <= 1'b0;
      frame_error  <= 1'b0;
      if (w_sample)
        r_shift <= w_slot[18:0];

      // A sync rise always restarts framing; outside HUNT it also kills the current frame.
      if (w_sync_rise) begin
        r_bit_cnt <= 8'd1;
        r_state   <= (BIT0_DELAY == 0) ? SLOT0 : ALIGN;
        if (r_state != HUNT) begin
          frame_error <= 1'b1;
`ifdef AC97_RX_FRAME_STATS_EN
          if (error_count != 8'hFF)
            error_count <= error_count + 8'd1;
`endif
        end
      end else begin
        case (r_state)
          HUNT: ;
          ALIGN: begin
            if (w_sample) begin
              r_state   <= SLOT0;
              r_bit_cnt <= 8'd1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 8'd1;
            end
          end
          SLOT0: begin
            r_bit_cnt <= r_bit_cnt + 8'd1;
            if (r_bit_cnt == 8'd15) begin
              codec_ready <= w_slot[15];
              slot_tags   <= w_slot[14:3];
              r_state     <= DATA;
            end
          end
          DATA: begin
            r_bit_cnt <= r_bit_cnt + 8'd1;
            case (r_bit_cnt)
              8'd35: r_addr_hold <= w_slot[18:12];
              8'd55: begin
                if (codec_ready && slot_tags[11] && slot_tags[10]) begin
                  status_addr  <= r_addr_hold;
                  status_data  <= w_slot[19:4];
                  status_valid <= 1'b1;
                end
              end
              8'd75: r_left_hold <= w_slot[19 -: PCM_WIDTH];
              8'd95: begin
                if (codec_ready) begin
                  if (slot_tags[9])
                    pcm_left <= r_left_hold;
                  if (slot_tags[8])
                    pcm_right <= w_slot[19 -: PCM_WIDTH];
                  pcm_valid <= slot_tags[9] | slot_tags[8];
                end
              end
              8'd255: begin
                r_state   <= HUNT;
                r_bit_cnt <= '0;
`ifdef AC97_RX_FRAME_STATS_EN
                frame_count <= frame_count + 16'd1;
`endif
              end
              default: ;
            endcase
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ac97_link_receiver.sv
// Scoreboard bench for ac97_link_receiver: instance A uses defaults, instance B uses BIT0_DELAY=0, PCM_WIDTH=20.
module tb_ac97_link_receiver;

  typedef struct {
    int          cyc;
    logic [31:0] v0;
    logic [31:0] v1;
  } exp_t;

  logic clk = 1'b0;
  logic reset_b = 1'b0;
  logic sync_a = 1'b0, sdata_a = 1'b0, sync_b = 1'b0, sdata_b = 1'b0;

  logic        a_ready, a_sv, a_pv, a_err;
  logic [11:0] a_tags;
  logic [6:0]  a_addr;
  logic [15:0] a_data, a_left, a_right;
  logic        b_ready, b_sv, b_pv, b_err;
  logic [11:0] b_tags;
  logic [6:0]  b_addr;
  logic [15:0] b_data;
  logic [19:0] b_left, b_right;
`ifdef AC97_RX_FRAME_STATS_EN
  logic [15:0] a_fcnt, b_fcnt;
  logic [7:0]  a_ecnt, b_ecnt;
`endif

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  exp_t st_q[$];
  exp_t pcm_qa[$];
  exp_t pcm_qb[$];
  int   err_qa[$];
  int   err_qb[$];
  exp_t e_st, e_pa, e_pb;
  int   e_cyc;

  logic [19:0] cur_l[2];
  logic [19:0] cur_r[2];
  int          exp_frames[2];
  int          exp_errs[2];

  ac97_link_receiver u_dut_a (
    .clk(clk), .reset_b(reset_b), .ac97_sync(sync_a), .ac97_sdata_in(sdata_a),
    .codec_ready(a_ready), .slot_tags(a_tags), .status_addr(a_addr), .status_data(a_data),
    .status_valid(a_sv), .pcm_left(a_left), .pcm_right(a_right), .pcm_valid(a_pv),
`ifdef AC97_RX_FRAME_STATS_EN
    .frame_count(a_fcnt), .error_count(a_ecnt),
`endif
    .frame_error(a_err)
  );

  ac97_link_receiver #(.BIT0_DELAY(0), .PCM_WIDTH(20)) u_dut_b (
    .clk(clk), .reset_b(reset_b), .ac97_sync(sync_b), .ac97_sdata_in(sdata_b),
    .codec_ready(b_ready), .slot_tags(b_tags), .status_addr(b_addr), .status_data(b_data),
    .status_valid(b_sv), .pcm_left(b_left), .pcm_right(b_right), .pcm_valid(b_pv),
`ifdef AC97_RX_FRAME_STATS_EN
    .frame_count(b_fcnt), .error_count(b_ecnt),
`endif
    .frame_error(b_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Drives one frame: sync high for 16 bits, bit k presented so it is sampled BIT0_DELAY+k edges after the rise.
  // nbits < 256 stops early; abort=1 means the next call starts immediately and kills this frame.
  task automatic send_frame(input int sel, input logic [15:0] tag, input logic [19:0] s1, input logic [19:0] s2,
                            input logic [19:0] s3, input logic [19:0] s4, input int nbits, input bit abort);
    logic [255:0] fr;
    int d;
    int p0;
    fr = '0;
    fr[255 -: 16] = tag;
    fr[239 -: 20] = s1;
    fr[219 -: 20] = s2;
    fr[199 -: 20] = s3;
    fr[179 -: 20] = s4;
    d = (sel == 0) ? 1 : 0;
    for (int j = 0; j < d + nbits; j++) begin
      @(negedge clk);
      if (j == 0) begin
        p0 = cyc + 1;
        if (sel == 0 && nbits > 55 && tag[15] && tag[14] && tag[13])
          st_q.push_back('{p0 + d + 55, 32'(s1[18:12]), 32'(s2[19:4])});
        if (nbits > 95 && tag[15] && (tag[12] || tag[11])) begin
          if (tag[12]) cur_l[sel] = (sel == 1) ? s3 : {4'h0, s3[19:4]};
          if (tag[11]) cur_r[sel] = (sel == 1) ? s4 : {4'h0, s4[19:4]};
          if (sel == 0) pcm_qa.push_back('{p0 + d + 95, 32'(cur_l[0]), 32'(cur_r[0])});
          else          pcm_qb.push_back('{p0 + d + 95, 32'(cur_l[1]), 32'(cur_r[1])});
        end
        if (abort) begin
          if (sel == 0) err_qa.push_back(p0 + d + nbits);
          else          err_qb.push_back(p0 + d + nbits);
          if (exp_errs[sel] < 255) exp_errs[sel]++;
        end
        if (nbits == 256) exp_frames[sel]++;
      end
      if (sel == 0) begin
        sync_a  = (j < 16);
        sdata_a = (j >= d) ? fr[255 - (j - d)] : 1'b0;
      end else begin
        sync_b  = (j < 16);
        sdata_b = (j >= d) ? fr[255 - (j - d)] : 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sync_a = 1'b0; sdata_a = 1'b0; sync_b = 1'b0; sdata_b = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      cur_l[i] = '0; cur_r[i] = '0; exp_frames[i] = 0; exp_errs[i] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (a_sv) begin
      check_eq("status_expected_a", 32'(st_q.size() != 0), 32'd1);
      if (st_q.size() != 0) begin
        e_st = st_q.pop_front();
        $display("status_valid A cyc=%0d addr=%h data=%h", cyc, a_addr, a_data);
        check_eq("status_cycle", cyc, e_st.cyc);
        check_eq("status_addr", 32'(a_addr), e_st.v0);
        check_eq("status_data", 32'(a_data), e_st.v1);
      end
    end
    if (b_sv) check_eq("status_valid_b_unexpected", 32'(b_sv), 32'd0);
    if (a_pv) begin
      check_eq("pcm_expected_a", 32'(pcm_qa.size() != 0), 32'd1);
      if (pcm_qa.size() != 0) begin
        e_pa = pcm_qa.pop_front();
        $display("pcm_valid A cyc=%0d left=%h right=%h", cyc, a_left, a_right);
        check_eq("pcm_cycle_a", cyc, e_pa.cyc);
        check_eq("pcm_left_a", 32'(a_left), e_pa.v0);
        check_eq("pcm_right_a", 32'(a_right), e_pa.v1);
      end
    end
    if (b_pv) begin
      check_eq("pcm_expected_b", 32'(pcm_qb.size() != 0), 32'd1);
      if (pcm_qb.size() != 0) begin
        e_pb = pcm_qb.pop_front();
        $display("pcm_valid B cyc=%0d left=%h right=%h", cyc, b_left, b_right);
        check_eq("pcm_cycle_b", cyc, e_pb.cyc);
        check_eq("pcm_left_b", 32'(b_left), e_pb.v0);
        check_eq("pcm_right_b", 32'(b_right), e_pb.v1);
      end
    end
    if (a_err) begin
      check_eq("frame_error_expected_a", 32'(err_qa.size() != 0), 32'd1);
      if (err_qa.size() != 0) begin
        e_cyc = err_qa.pop_front();
        $display("frame_error A cyc=%0d", cyc);
        check_eq("frame_error_cycle_a", cyc, e_cyc);
      end
    end
    if (b_err) begin
      check_eq("frame_error_expected_b", 32'(err_qb.size() != 0), 32'd1);
      if (err_qb.size() != 0) begin
        e_cyc = err_qb.pop_front();
        $display("frame_error B cyc=%0d", cyc);
        check_eq("frame_error_cycle_b", cyc, e_cyc);
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_codec_ready", 32'(a_ready), 32'd0);
    check_eq("rst_slot_tags", 32'(a_tags), 32'd0);
    check_eq("rst_status_addr", 32'(a_addr), 32'd0);
    check_eq("rst_status_data", 32'(a_data), 32'd0);
    check_eq("rst_pulses", 32'({a_sv, a_pv, a_err}), 32'd0);
    check_eq("rst_pcm_a", 32'({a_left, a_right}), 32'd0);
    check_eq("rst_pcm_b", 32'({b_left, b_right}), 32'd0);
    reset_b = 1'b1;
    idle(3);

    // Status read-back frame (PCM slots also valid).
    send_frame(0, 16'hF800, 20'h26000, 20'h000F0, 20'h11110, 20'h22220, 256, 0);
    idle(2);
    check_eq("f1_codec_ready", 32'(a_ready), 32'd1);
    check_eq("f1_slot_tags", 32'(a_tags), 32'hF00);
    check_eq("f1_status_addr", 32'(a_addr), 32'h26);
    check_eq("f1_status_data", 32'(a_data), 32'h000F);

    // PCM-only frame; status must hold.
    send_frame(0, 16'h9800, 20'h7F000, 20'hFFFF0, 20'h12340, 20'hABCD0, 256, 0);
    idle(1);
    check_eq("f2_pcm_left", 32'(a_left), 32'h1234);
    check_eq("f2_pcm_right", 32'(a_right), 32'hABCD);
    check_eq("f2_status_addr_hold", 32'(a_addr), 32'h26);
    check_eq("f2_status_data_hold", 32'(a_data), 32'h000F);

    // Codec not ready: nothing published.
    send_frame(0, 16'h7800, 20'h11000, 20'h55550, 20'h66660, 20'h77770, 256, 0);
    idle(1);
    check_eq("f3_codec_ready", 32'(a_ready), 32'd0);
    check_eq("f3_slot_tags", 32'(a_tags), 32'hF00);
    check_eq("f3_pcm_left_hold", 32'(a_left), 32'h1234);

    // Early sync at bit 100, then a full frame immediately.
    send_frame(0, 16'hF800, 20'h55000, 20'hCAFE0, 20'h0AAA0, 20'h0BBB0, 100, 1);
    send_frame(0, 16'hE000, 20'h33000, 20'h76540, 20'h0, 20'h0, 256, 0);
    idle(2);
    check_eq("f5_status_addr", 32'(a_addr), 32'h33);
    check_eq("f5_status_data", 32'(a_data), 32'h7654);
`ifdef AC97_RX_FRAME_STATS_EN
    check_eq("f5_error_count", 32'(a_ecnt), 32'(exp_errs[0]));
    check_eq("f5_frame_count", 32'(a_fcnt), 32'(exp_frames[0]));
`endif

    // Reset in the middle of a status frame.
    send_frame(0, 16'hF800, 20'h3A000, 20'h12340, 20'h0, 20'h0, 41, 0);
    @(negedge clk);
    reset_b = 1'b0;
    sdata_a = 1'b0;
    sync_a  = 1'b0;
    #1;
    model_reset();
    check_eq("mid_rst_codec_ready", 32'(a_ready), 32'd0);
    check_eq("mid_rst_tags", 32'(a_tags), 32'd0);
    check_eq("mid_rst_status", 32'({a_addr, a_data}), 32'd0);
    check_eq("mid_rst_pcm", 32'({a_left, a_right}), 32'd0);
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    idle(3);
    send_frame(0, 16'hF800, 20'h5B000, 20'hBEEF0, 20'h0, 20'h0, 256, 0);
    idle(2);
    check_eq("post_rst_status_addr", 32'(a_addr), 32'h5B);
    check_eq("post_rst_status_data", 32'(a_data), 32'hBEEF);

    // Zero-delay, full-width instance: back-to-back frames with no idle bits.
    send_frame(1, 16'h9800, 20'h0, 20'h0, 20'h80001, 20'h0F0F0, 256, 0);
    send_frame(1, 16'h9800, 20'h0, 20'h0, 20'h7FFFE, 20'h12345, 256, 0);
    idle(4);
    check_eq("b_pcm_left", 32'(b_left), 32'h7FFFE);
    check_eq("b_pcm_right", 32'(b_right), 32'h12345);
    check_eq("b_codec_ready", 32'(b_ready), 32'd1);

    // Trailing bits with no sync must be ignored.
    repeat (40) begin
      @(negedge clk);
      sdata_a = 1'($urandom_range(0, 1));
      sdata_b = 1'($urandom_range(0, 1));
    end
    idle(20);
`ifdef AC97_RX_FRAME_STATS_EN
    check_eq("end_frame_count_a", 32'(a_fcnt), 32'(exp_frames[0]));
    check_eq("end_error_count_a", 32'(a_ecnt), 32'(exp_errs[0]));
    check_eq("end_frame_count_b", 32'(b_fcnt), 32'(exp_frames[1]));
    check_eq("end_error_count_b", 32'(b_ecnt), 32'(exp_errs[1]));
`endif
    check_eq("status_q_drained", 32'(st_q.size()), 32'd0);
    check_eq("pcm_qa_drained", 32'(pcm_qa.size()), 32'd0);
    check_eq("pcm_qb_drained", 32'(pcm_qb.size()), 32'd0);
    check_eq("err_qa_drained", 32'(err_qa.size()), 32'd0);
    check_eq("err_qb_drained", 32'(err_qb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
